// File: rtl/sad_if.sv
// Beat/result bundle for the SAD accumulator.
//
// master (beat source / result sink):
//   drives  in_valid, in_first, cur_pix, ref_pix, mv_in, mv_last_in
//   reads   sad_out, mv_out, sad_valid, sad_last, err
// slave (the accumulator): the mirror image.
//
// Pixel lanes are packed with lane i at bits [i*PIX_W +: PIX_W].
interface sad_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 8,
  parameter int SAD_W = 16,
  parameter int MV_W  = 14
);
  logic                   in_valid;
  logic                   in_first;
  logic [LANES*PIX_W-1:0] cur_pix;
  logic [LANES*PIX_W-1:0] ref_pix;
  logic [MV_W-1:0]        mv_in;
  logic                   mv_last_in;
  logic [SAD_W-1:0]       sad_out;
  logic [MV_W-1:0]        mv_out;
  logic                   sad_valid;
  logic                   sad_last;
  logic                   err;

  modport master (
    output in_valid, in_first, cur_pix, ref_pix, mv_in, mv_last_in,
    input  sad_out, mv_out, sad_valid, sad_last, err
  );

  modport slave (
    input  in_valid, in_first, cur_pix, ref_pix, mv_in, mv_last_in,
    output sad_out, mv_out, sad_valid, sad_last, err
  );
endinterface

// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences accumulator for block motion search.
//
// One row of LANES pixel pairs arrives per beat; BEATS beats form one
// candidate block. The result for each candidate is emitted with the
// motion vector and end-of-window flag captured on its first beat.
// Pipeline: input framing + per-lane |cur-ref| -> lane adder tree ->
// block accumulator (saturating) -> output register.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    sad_if slave modport (beat inputs, SAD/MV/valid/last/err outputs)
//
// Latency: last beat accepted at edge k -> sad_valid high after edge k+3.
module sad_accumulator #(
  parameter int PIX_W = 8,
  parameter int LANES = 8,
  parameter int BEATS = 8,
  parameter int SAD_W = 16,
  parameter int MV_W  = 14
) (
  input  logic clk,
  input  logic reset,
  sad_if.slave bus
);

  localparam int SUM_W = PIX_W + $clog2(LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // One guard bit above the wider operand so the add can never wrap
  // before the saturation compare sees it.
  localparam int EXT_W = ((SAD_W > SUM_W) ? SAD_W : SUM_W) + 1;
  localparam logic [EXT_W-1:0] SAT_LIM = {{(EXT_W-SAD_W){1'b0}}, {SAD_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  // ---------------------------------------------------------------------
  // Input framing
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             beat_ok;
  logic             beat_last;
  logic             err_next;
  logic [MV_W-1:0]  cand_mv;
  logic             cand_last;

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    cnt_next  = cnt;
    beat_ok   = bus.in_valid && (bus.in_first || cnt != '0);
    // A first beat mid-block abandons the partial block; a continuation
    // beat with no open block is dropped. Both are reported.
    err_next  = bus.in_valid && (bus.in_first ? (cnt != '0) : (cnt == '0));
    beat_last = bus.in_first ? (BEATS == 1) : (cnt == CNT_LAST);
    if (beat_ok) begin
      if (beat_last)         cnt_next = '0;
      else if (bus.in_first) cnt_next = CNT_W'(1);
      else                   cnt_next = cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: per-lane absolute difference
  // ---------------------------------------------------------------------
  logic [PIX_W-1:0] cur_lane [LANES];
  logic [PIX_W-1:0] ref_lane [LANES];
  logic [PIX_W-1:0] diff     [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign cur_lane[i] = bus.cur_pix[i*PIX_W +: PIX_W];
    assign ref_lane[i] = bus.ref_pix[i*PIX_W +: PIX_W];
    assign diff[i]     = (cur_lane[i] >= ref_lane[i]) ? cur_lane[i] - ref_lane[i]
                                                      : ref_lane[i] - cur_lane[i];
  end

  logic             s1_valid, s1_first, s1_last, s1_mv_last;
  logic [MV_W-1:0]  s1_mv;
  logic [PIX_W-1:0] s1_diff [LANES];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      bus.err    <= 1'b0;
      cand_mv    <= '0;
      cand_last  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_mv      <= '0;
      s1_mv_last <= 1'b0;
      s1_diff    <= '{default: '0};
    end else begin
      cnt      <= cnt_next;
      bus.err  <= err_next;
      s1_valid <= beat_ok;
      if (beat_ok && bus.in_first) begin
        cand_mv   <= bus.mv_in;
        cand_last <= bus.mv_last_in;
      end
      if (beat_ok) begin
        s1_first   <= bus.in_first;
        s1_last    <= beat_last;
        // The candidate registers update on this same edge, so a first beat
        // (which may also be the last when BEATS==1) tags straight from the port.
        s1_mv      <= bus.in_first ? bus.mv_in      : cand_mv;
        s1_mv_last <= bus.in_first ? bus.mv_last_in : cand_last;
        s1_diff    <= diff;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: lane adder tree
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_W'(s1_diff[i]);
    end
  end

  logic             s2_valid, s2_first, s2_last, s2_mv_last;
  logic [MV_W-1:0]  s2_mv;
  logic [SUM_W-1:0] s2_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_first   <= 1'b0;
      s2_last    <= 1'b0;
      s2_mv      <= '0;
      s2_mv_last <= 1'b0;
      s2_sum     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first   <= s1_first;
        s2_last    <= s1_last;
        s2_mv      <= s1_mv;
        s2_mv_last <= s1_mv_last;
        s2_sum     <= lane_sum;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: saturating block accumulator
  // ---------------------------------------------------------------------
  logic [SAD_W-1:0] acc, acc_next;
  logic [EXT_W-1:0] acc_wide;
  logic             acc_done, acc_mv_last;
  logic [MV_W-1:0]  acc_mv;

  always_comb begin
    // A first-tagged beat restarts the block, discarding any partial sum.
    acc_wide = (s2_first ? '0 : EXT_W'(acc)) + EXT_W'(s2_sum);
    acc_next = (acc_wide > SAT_LIM) ? SAT_LIM[SAD_W-1:0] : acc_wide[SAD_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      acc_done    <= 1'b0;
      acc_mv      <= '0;
      acc_mv_last <= 1'b0;
    end else begin
      acc_done <= s2_valid && s2_last;
      if (s2_valid) begin
        acc         <= acc_next;
        acc_mv      <= s2_mv;
        acc_mv_last <= s2_mv_last;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register: results hold until the next completed block.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sad_valid <= 1'b0;
      bus.sad_out   <= '0;
      bus.mv_out    <= '0;
      bus.sad_last  <= 1'b0;
    end else begin
      bus.sad_valid <= acc_done;
      if (acc_done) begin
        bus.sad_out  <= acc;
        bus.mv_out   <= acc_mv;
        bus.sad_last <= acc_mv_last;
      end
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// Self-checking bench for sad_accumulator.
// Two instances share one beat stream: a default build (SAD_W=16) and a
// narrow build (SAD_W=12) that exercises saturation. Expected results are
// queued when each candidate's last beat is driven; a monitor records what
// the DUTs emit, and the two queues are compared after each scenario.
module tb_sad_accumulator;

  localparam int PIX_W = 8;
  localparam int LANES = 8;
  localparam int BEATS = 8;
  localparam int MV_W  = 14;
  localparam int SAD_W = 16;
  localparam int SAT_W = 12;
  localparam int DW    = LANES * PIX_W;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid   = 1'b0;
  logic            in_first   = 1'b0;
  logic [DW-1:0]   cur_pix    = '0;
  logic [DW-1:0]   ref_pix    = '0;
  logic [MV_W-1:0] mv_in      = '0;
  logic            mv_last_in = 1'b0;

  sad_if #(.PIX_W(PIX_W), .LANES(LANES), .SAD_W(SAD_W), .MV_W(MV_W)) bus_a ();
  sad_if #(.PIX_W(PIX_W), .LANES(LANES), .SAD_W(SAT_W), .MV_W(MV_W)) bus_b ();

  assign bus_a.in_valid   = in_valid;
  assign bus_a.in_first   = in_first;
  assign bus_a.cur_pix    = cur_pix;
  assign bus_a.ref_pix    = ref_pix;
  assign bus_a.mv_in      = mv_in;
  assign bus_a.mv_last_in = mv_last_in;
  assign bus_b.in_valid   = in_valid;
  assign bus_b.in_first   = in_first;
  assign bus_b.cur_pix    = cur_pix;
  assign bus_b.ref_pix    = ref_pix;
  assign bus_b.mv_in      = mv_in;
  assign bus_b.mv_last_in = mv_last_in;

  sad_accumulator #(.PIX_W(PIX_W), .LANES(LANES), .BEATS(BEATS), .SAD_W(SAD_W), .MV_W(MV_W))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  sad_accumulator #(.PIX_W(PIX_W), .LANES(LANES), .BEATS(BEATS), .SAD_W(SAT_W), .MV_W(MV_W))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    int sad;
    int mv;
    int last;
    int cyc;
  } res_t;

  res_t exp_a[$];
  res_t exp_b[$];
  res_t obs_a[$];
  res_t obs_b[$];

  int cyc        = 0;
  int err_pulses = 0;
  int checks     = 0;
  int errors     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (bus_a.sad_valid === 1'b1)
      obs_a.push_back('{int'(bus_a.sad_out), int'(bus_a.mv_out), int'(bus_a.sad_last), cyc});
    if (bus_b.sad_valid === 1'b1)
      obs_b.push_back('{int'(bus_b.sad_out), int'(bus_b.mv_out), int'(bus_b.sad_last), cyc});
    if (bus_a.err === 1'b1) err_pulses = err_pulses + 1;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic first, input logic [DW-1:0] c, input logic [DW-1:0] r,
                            input logic [MV_W-1:0] mv, input logic mvl);
    @(negedge clk);
    in_valid   = 1'b1;
    in_first   = first;
    cur_pix    = c;
    ref_pix    = r;
    mv_in      = mv;
    mv_last_in = mvl;
  endtask

  function automatic int beat_sad(input logic [DW-1:0] c, input logic [DW-1:0] r);
    int s = 0;
    for (int i = 0; i < LANES; i++) begin
      int a = int'(c[i*PIX_W +: PIX_W]);
      int b = int'(r[i*PIX_W +: PIX_W]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  // Drives nbeats of one candidate (fewer than BEATS leaves it partial).
  // Non-first beats carry inverted MV/last so any late sampling shows up.
  task automatic send_cand(input logic [MV_W-1:0] mv, input logic mvl, input int nbeats,
                           input logic rnd, input logic [7:0] dc, input logic [7:0] dr,
                           input int gap_at, input int gap_len);
    int sad = 0;
    logic [DW-1:0] c, r;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) idle(gap_len);
      if (rnd) begin
        c = {$urandom(), $urandom()};
        r = {$urandom(), $urandom()};
      end else begin
        c = {LANES{dc}};
        r = {LANES{dr}};
      end
      sad += beat_sad(c, r);
      if (b == 0) drive_beat(1'b1, c, r, mv, mvl);
      else        drive_beat(1'b0, c, r, ~mv, ~mvl);
      if (b == BEATS - 1) begin
        // Accepted at the coming edge (cyc+1); valid visible after 3 more edges.
        exp_a.push_back('{sad, int'(mv), int'(mvl), cyc + 4});
        exp_b.push_back('{(sad > SAT_MAX) ? SAT_MAX : sad, int'(mv), int'(mvl), cyc + 4});
      end
    end
  endtask

  task automatic drain(input string tag);
    res_t o, e;
    idle(8);
    check({tag, "_count"}, obs_a.size(), exp_a.size());
    check({tag, "_count_sat"}, obs_b.size(), exp_b.size());
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front();
      e = exp_a.pop_front();
      check({tag, "_sad"}, o.sad, e.sad);
      check({tag, "_mv"}, o.mv, e.mv);
      check({tag, "_last"}, o.last, e.last);
      check({tag, "_cycle"}, o.cyc, e.cyc);
    end
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      o = obs_b.pop_front();
      e = exp_b.pop_front();
      check({tag, "_sad_sat"}, o.sad, e.sad);
    end
    obs_a.delete(); exp_a.delete();
    obs_b.delete(); exp_b.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sad_out"},   int'(bus_a.sad_out),   0);
    check({tag, "_mv_out"},    int'(bus_a.mv_out),    0);
    check({tag, "_sad_valid"}, int'(bus_a.sad_valid), 0);
    check({tag, "_sad_last"},  int'(bus_a.sad_last),  0);
    check({tag, "_err"},       int'(bus_a.err),       0);
    check({tag, "_sad_out_sat"}, int'(bus_b.sad_out), 0);
  endtask

  int err_base;

  initial begin
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Single candidate: |10-7| * 64 = 192.
    send_cand(14'h0123, 1'b0, 8, 1'b0, 8'd10, 8'd7, -1, 0);
    drain("single");

    // Back-to-back: 64 then 16320 (12-bit build clamps to 4095).
    send_cand(14'h0001, 1'b0, 8, 1'b0, 8'd5, 8'd4, -1, 0);
    send_cand(14'h0002, 1'b1, 8, 1'b0, 8'd255, 8'd0, -1, 0);
    drain("b2b");

    // Gap of 3 idle cycles after beat 4: same sum (5*64), later by 3.
    send_cand(14'h0777, 1'b0, 8, 1'b0, 8'd20, 8'd25, 4, 3);
    drain("gap");

    // Random pixels, three candidates back-to-back.
    send_cand(14'h1abc, 1'b0, 8, 1'b1, 8'd0, 8'd0, -1, 0);
    send_cand(14'h2def, 1'b1, 8, 1'b1, 8'd0, 8'd0, -1, 0);
    send_cand(14'h3fff, 1'b0, 8, 1'b1, 8'd0, 8'd0, 2, 1);
    drain("random");
    check("err_none", err_pulses, 0);

    // Framing: first beat at beat 5 of A, then a stray beat with no block open.
    err_base = err_pulses;
    send_cand(14'h00aa, 1'b1, 5, 1'b0, 8'd9, 8'd1, -1, 0);
    send_cand(14'h00bb, 1'b0, 8, 1'b0, 8'd3, 8'd5, -1, 0);
    drive_beat(1'b0, {LANES{8'd50}}, '0, 14'h0111, 1'b1);
    drain("framing");
    check("err_framing", err_pulses - err_base, 2);

    // Reset at beat 6 of a candidate, then a clean diff-3 candidate (192).
    send_cand(14'h0444, 1'b0, 6, 1'b0, 8'd200, 8'd0, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1 check_outputs_zero("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_cand(14'h0555, 1'b1, 8, 1'b0, 8'd3, 8'd0, -1, 0);
    drain("after_rst");

    // Reset while a completed block is still in the pipeline: nothing emerges.
    send_cand(14'h0666, 1'b0, 8, 1'b0, 8'd40, 8'd0, -1, 0);
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1 check_outputs_zero("rst_inflight");
    @(negedge clk);
    reset = 1'b0;
    drain("inflight");
    check("err_total", err_pulses - err_base, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_accumulator.md
# sad_accumulator

Computes the sum of absolute differences (SAD) between a current-frame block and a reference-frame candidate block, streamed in one row of pixels per beat, and emits one SAD per candidate together with that candidate's motion vector. Sits directly upstream of the motion-vector selector stage and produces the SAD, write-enable and MV stream that stage consumes. Three-stage pipeline: per-lane absolute difference, lane adder tree, block accumulator.

## Interface

- PIX_W, 8, pixel width in bits
- LANES, 8, pixels compared per beat
- BEATS, 8, beats per candidate block; default block is 8x8
- SAD_W, 16, output SAD width
- MV_W, 14, motion-vector width
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  beat present this cycle
- in_first  input  1  first beat of a candidate; qualified by in_valid
- cur_pix  input  LANES*PIX_W  current-block pixels; lane i = bits [i*PIX_W +: PIX_W]
- ref_pix  input  LANES*PIX_W  reference-candidate pixels, same packing
- mv_in  input  MV_W  candidate MV; sampled on the first beat only
- mv_last_in  input  1  candidate is the last of its search window; sampled on the first beat only
- sad_out  output  SAD_W  completed SAD
- mv_out  output  MV_W  MV of the completed candidate
- sad_valid  output  1  one-cycle pulse; sad_out and mv_out valid
- sad_last  output  1  copy of mv_last_in for this candidate; valid with sad_valid
- err  output  1  one-cycle pulse on framing error

## Operation

- No backpressure: every accepted beat is processed; the downstream stage must accept every sad_valid pulse.
- Beat counter cnt (0..BEATS-1). Beat accepted when in_valid=1 and either in_first=1 or cnt!=0.
- in_first=1 accepted: cnt<=1 (or 0 if BEATS==1); mv_in and mv_last_in captured into candidate registers.
- Continuation beat: cnt<=cnt+1; wraps to 0 after beat BEATS-1. That beat is tagged last.
- Framing errors, err pulses one cycle after the offending edge:
  - in_first=1 while cnt!=0: partial candidate discarded (no sad_valid for it); new candidate starts normally.
  - in_valid=1, in_first=0, cnt==0: beat dropped, no state change.
- Stage 1: per lane |cur-ref|, PIX_W bits unsigned; registered with valid/first/last tags.
- Stage 2: sum of LANES differences, PIX_W+clog2(LANES) bits; registered with tags.
- Stage 3: on a first-tagged beat the accumulator loads the lane sum; otherwise it adds. Accumulator saturates at 2^SAD_W-1 and never wraps. The default max is 64*255 = 16320, so there is no saturation by default.
- On a last-tagged beat: sad_out <= final accumulated value; mv_out/sad_last <= the candidate registers tagged to that block; sad_valid <= 1.
- The MV/last captured for candidate N travels with its tags, so a following first beat cannot corrupt it.
- sad_out, mv_out and sad_last hold until the next sad_valid.

## Timing

- Reset: cnt=0, all pipeline valids 0, accumulator 0. Outputs sad_out=0, mv_out=0, sad_valid=0, sad_last=0, err=0.
- Latency: last beat accepted at edge k → sad_valid high for the cycle after edge k+3.
- Throughput: one beat per cycle. Back-to-back candidates need no idle cycle, giving one SAD every BEATS cycles.
- in_valid may drop mid-candidate; gaps are allowed and the count resumes.
- Reset asserted mid-candidate: all in-flight data discarded, no sad_valid emitted after reset release.
- BEATS==1: every beat must carry in_first; each beat produces one SAD.

## Test plan

- Single candidate: cur all 8'd10, ref all 8'd7, 8 beats, mv_in=14'h0123, mv_last_in=0 → one sad_valid, 3 cycles after the last beat's edge; sad_out=192, mv_out=14'h0123, sad_last=0.
- Back-to-back: candidate A diff 1 per pixel (mv 14'h0001), candidate B diff 255 per pixel (mv 14'h0002, mv_last_in=1), no gap → sad_out=64 then 16320, exactly 8 cycles apart; second pulse has sad_last=1 and mv_out=14'h0002.
- Gapped beats: candidate A with in_valid low for 3 cycles after beat 4 → sad_out unchanged from the gapless run; sad_valid delayed by 3 cycles.
- Framing: in_first at beat 5 of candidate A, then a full candidate B (diff 2) → err pulse; no output for A; B outputs sad_out=128. A stray beat with cnt==0 and in_first=0 → err pulse, no output.
- Saturation: SAD_W=12 build, diff 255 per pixel → sad_out=4095.
- Reset at beat 6 of a candidate, released, then a full candidate with diff 3 → only one sad_valid, sad_out=192; every output is 0 during reset.
